// File: rtl/hit_score_reader_pkg.sv
// hit_score_reader_pkg: shared constants, field slices and state encoding for the hit-score reader.
// Rev 1.0
`default_nettype none

package hit_score_reader_pkg;

  localparam int MEMORY_ADDRESS   = 14;
  localparam int MEMORY_DATAWIDTH = 64;
  localparam int LENGTH_COUNTER   = 8;
  localparam int COUNT_W          = 29;
  localparam int HIT_BASE         = 16262;

  localparam logic [MEMORY_ADDRESS-1:0] HIT_BASE_ADDR = MEMORY_ADDRESS'(HIT_BASE);
  // Records fill the words above the header up to the top of the address space.
  localparam logic [COUNT_W-1:0] REC_CAP = COUNT_W'((2 ** MEMORY_ADDRESS) - 1 - HIT_BASE);

  localparam int SCORE_LSB  = 0;
  localparam int LENGTH_LSB = LENGTH_COUNTER;
  localparam int S_ADDR_LSB = 2 * LENGTH_COUNTER;
  localparam int Q_ADDR_LSB = 3 * LENGTH_COUNTER;

  localparam logic [7:0] FINISHED_CODE = 8'hEE;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RD_HDR   = 3'd1;
  localparam state_t ST_WAIT_HDR = 3'd2;
  localparam state_t ST_STREAM   = 3'd3;
  localparam state_t ST_DONE     = 3'd4;

  function automatic logic [COUNT_W-1:0] clamp_count(input logic [31:0] len);
    return (len[31:3] > REC_CAP) ? REC_CAP : len[31:3];
  endfunction

  function automatic logic len_bad(input logic [31:0] len);
    return (len[2:0] != 3'd0) || (len[31:3] > REC_CAP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hit_fifo2.sv
// hit_fifo2: 2-entry {last,data} FIFO whose head falls through straight from the write port when empty.
// Rev 1.0
`default_nettype none

module hit_fifo2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [32:0] din,
  input  logic        pop,
  output logic        valid,
  output logic [32:0] dout,
  output logic [1:0]  count
);

  logic [32:0] r_mem [2];
  logic        r_wr;
  logic        r_rd;
  logic [1:0]  r_count;
  logic        w_empty;
  logic        w_store;
  logic        w_take;

  // A push that is popped in the same cycle while empty bypasses storage entirely.
  always_comb begin
    w_empty = (r_count == 2'd0);
    w_store = push && !(w_empty && pop);
    w_take  = pop && !w_empty;
  end

  assign valid = !w_empty || push;
  assign dout  = !w_empty ? r_mem[r_rd] : (push ? din : 33'd0);
  assign count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_store) begin
        r_mem[r_wr] <= din;
        r_wr        <= ~r_wr;
      end
      if (w_take) begin
        r_rd <= ~r_rd;
      end
      r_count <= r_count + {1'b0, w_store} - {1'b0, w_take};
    end
  end

endmodule

`default_nettype wire

// File: rtl/hit_score_reader.sv
// hit_score_reader: reads the hit-score header, then prefetches and streams each record on valid/ready.
// Rev 1.0
`default_nettype none

module hit_score_reader
  import hit_score_reader_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [31:0]                 subject_id,
  output logic [COUNT_W-1:0]          record_count,
  output logic                        header_valid,
  output logic                        len_error,
  output logic [MEMORY_ADDRESS-1:0]   memory_address,
  output logic                        memory_read,
  input  logic [MEMORY_DATAWIDTH-1:0] memory_readdata,
  output logic                        rec_valid,
  input  logic                        rec_ready,
  output logic [31:0]                 rec_data,
  output logic                        rec_last
);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [COUNT_W-1:0]        r_issued;
  logic [MEMORY_ADDRESS-1:0] r_ptr;
  logic [MEMORY_ADDRESS-1:0] r_addr;
  logic                      r_pend;
  logic                      r_pend_last;
  logic                      w_rd_hdr;
  logic                      w_issue;
  logic                      w_pop;
  logic [COUNT_W-1:0]        w_hdr_count;
  logic [1:0]                w_fifo_count;
  logic [32:0]               w_fifo_dout;

  assign w_hdr_count = clamp_count(memory_readdata[31:0]);
  assign w_pop       = rec_valid && rec_ready;

  // The in-flight read is counted so the FIFO can never be over-committed.
  assign w_issue = (r_state == ST_STREAM)
                && (({1'b0, w_fifo_count} + {2'b00, r_pend}) < 3'd2)
                && (r_issued < record_count);

  assign memory_read    = w_rd_hdr || w_issue;
  assign memory_address = w_rd_hdr ? HIT_BASE_ADDR : (w_issue ? r_ptr : r_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_next_state = ST_RD_HDR;
      ST_RD_HDR:   w_next_state = ST_WAIT_HDR;
      ST_WAIT_HDR: w_next_state = (w_hdr_count == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM:   if (w_pop && rec_last) w_next_state = ST_DONE;
      ST_DONE:     w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    w_rd_hdr = 1'b0;
    case (r_state)
      ST_RD_HDR: begin
        busy     = 1'b1;
        w_rd_hdr = 1'b1;
      end
      ST_WAIT_HDR: busy = 1'b1;
      ST_STREAM:   busy = 1'b1;
      ST_DONE:     done = 1'b1;
      default:     busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      subject_id   <= '0;
      record_count <= '0;
      header_valid <= 1'b0;
      len_error    <= 1'b0;
      r_issued     <= '0;
      r_ptr        <= '0;
      r_addr       <= '0;
      r_pend       <= 1'b0;
      r_pend_last  <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if ((r_state == ST_IDLE) && start) begin
        header_valid <= 1'b0;
        len_error    <= 1'b0;
        r_issued     <= '0;
        r_ptr        <= HIT_BASE_ADDR + MEMORY_ADDRESS'(1);
      end
      if (r_state == ST_RD_HDR) begin
        r_addr <= HIT_BASE_ADDR;
      end
      if (r_state == ST_WAIT_HDR) begin
        subject_id   <= memory_readdata[63:32];
        record_count <= w_hdr_count;
        len_error    <= len_bad(memory_readdata[31:0]);
        header_valid <= 1'b1;
      end
      if (w_issue) begin
        r_issued    <= r_issued + COUNT_W'(1);
        r_ptr       <= r_ptr + MEMORY_ADDRESS'(1);
        r_addr      <= r_ptr;
        r_pend_last <= (r_issued == (record_count - COUNT_W'(1)));
      end
    end
  end

  hit_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (r_pend),
    .din   ({r_pend_last, memory_readdata[31:0]}),
    .pop   (rec_ready),
    .valid (rec_valid),
    .dout  (w_fifo_dout),
    .count (w_fifo_count)
  );

  assign rec_data = w_fifo_dout[31:0];
  assign rec_last = w_fifo_dout[32];

endmodule

`default_nettype wire

// File: tb/tb_hit_score_reader.sv
// tb_hit_score_reader: directed self-checking bench for hit_score_reader.
// Rev 1.0
`default_nettype none

module tb_hit_score_reader;

  localparam int B = 16262;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, header_valid, len_error, memory_read;
  logic [31:0] subject_id;
  logic [28:0] record_count;
  logic [13:0] memory_address;
  logic [63:0] memory_readdata = 64'd0;
  logic        rec_valid, rec_last;
  logic        rec_ready = 1'b0;
  logic [31:0] rec_data;

  logic [63:0] mem [0:16383];
  int          rd_cnt = 0;
  logic [13:0] last_addr = 14'd0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memory_read) begin
      memory_readdata <= mem[memory_address];
      rd_cnt          <= rd_cnt + 1;
      last_addr       <= memory_address;
    end
  end

  hit_score_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .subject_id(subject_id), .record_count(record_count), .header_valid(header_valid),
    .len_error(len_error), .memory_address(memory_address), .memory_read(memory_read),
    .memory_readdata(memory_readdata), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_data(rec_data), .rec_last(rec_last)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick; tick;
    checks++; if ({busy, done, header_valid, len_error, memory_read, rec_valid, rec_last} !== 7'd0) begin errors++; $display("FAIL reset_flags got %b exp 0", {busy, done, header_valid, len_error, memory_read, rec_valid, rec_last}); end
    checks++; if ({subject_id, record_count, memory_address, rec_data} !== 107'd0) begin errors++; $display("FAIL reset_buses got %h exp 0", {subject_id, record_count, memory_address, rec_data}); end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int base_rd;
    mem[B]   = {32'h0000_0007, 32'h0000_0018};
    mem[B+1] = 64'h0000_0000_DEAD_CAF1;
    mem[B+2] = 64'h0000_0000_DEAD_CAF2;
    mem[B+3] = 64'h0000_0000_DEAD_CAF3;
    rec_ready = 1'b1;
    base_rd = rd_cnt;
    start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (rec_valid !== (c >= 4 && c <= 6)) begin errors++; $display("FAIL basic_valid c%0d got %b exp %b", c, rec_valid, (c >= 4 && c <= 6)); end
      if (c >= 4 && c <= 6) begin
        checks++; if (rec_data !== 32'hDEAD_CAF0 + 32'(c - 3)) begin errors++; $display("FAIL basic_data c%0d got %h exp %h", c, rec_data, 32'hDEAD_CAF0 + 32'(c - 3)); end
        checks++; if (rec_last !== (c == 6)) begin errors++; $display("FAIL basic_last c%0d got %b exp %b", c, rec_last, (c == 6)); end
      end
      checks++; if (done !== (c == 7)) begin errors++; $display("FAIL basic_done c%0d got %b exp %b", c, done, (c == 7)); end
      checks++; if (busy !== (c <= 6)) begin errors++; $display("FAIL basic_busy c%0d got %b exp %b", c, busy, (c <= 6)); end
      if (c == 3) begin
        checks++; if ({subject_id, record_count, header_valid, len_error} !== {32'd7, 29'd3, 1'b1, 1'b0}) begin errors++; $display("FAIL basic_header got %h/%0d/%b/%b exp 7/3/1/0", subject_id, record_count, header_valid, len_error); end
      end
      tick;
    end
    checks++; if (rd_cnt - base_rd !== 4) begin errors++; $display("FAIL basic_reads got %0d exp 4", rd_cnt - base_rd); end
  endtask

  task automatic test_zero_len;
    int base_rd;
    mem[B] = {32'h0000_0005, 32'h0000_0000};
    base_rd = rd_cnt;
    start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL zero_valid c%0d got %b exp 0", c, rec_valid); end
      checks++; if (done !== (c == 3)) begin errors++; $display("FAIL zero_done c%0d got %b exp %b", c, done, (c == 3)); end
      if (c == 3) begin
        checks++; if ({header_valid, record_count, len_error, subject_id} !== {1'b1, 29'd0, 1'b0, 32'd5}) begin errors++; $display("FAIL zero_header got %b/%0d/%b/%h exp 1/0/0/5", header_valid, record_count, len_error, subject_id); end
      end
      tick;
    end
    checks++; if (rd_cnt - base_rd !== 1) begin errors++; $display("FAIL zero_reads got %0d exp 1", rd_cnt - base_rd); end
  endtask

  task automatic test_backpressure;
    int base_rd, got;
    logic held, held_last, seen_done;
    logic [31:0] held_data;
    mem[B] = {32'h0000_0009, 32'h0000_0028};
    got = 0; held = 1'b0; seen_done = 1'b0; held_data = '0; held_last = 1'b0;
    base_rd = rd_cnt;
    start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      rec_ready = ((c % 3) == 1);
      if (done) begin seen_done = 1'b1; break; end
      if (held) begin
        checks++; if ({rec_valid, rec_last, rec_data} !== {1'b1, held_last, held_data}) begin errors++; $display("FAIL bp_stable c%0d got %b/%b/%h exp 1/%b/%h", c, rec_valid, rec_last, rec_data, held_last, held_data); end
      end
      checks++; if ((rd_cnt - base_rd - 1) - got > 2) begin errors++; $display("FAIL bp_ahead c%0d got %0d exp <=2", c, (rd_cnt - base_rd - 1) - got); end
      if (rec_valid && rec_ready) begin
        checks++; if ({rec_last, rec_data} !== {(got == 4), mem[B+1+got][31:0]}) begin errors++; $display("FAIL bp_data rec%0d got %b/%h exp %b/%h", got, rec_last, rec_data, (got == 4), mem[B+1+got][31:0]); end
        got++;
      end
      held = rec_valid && !rec_ready;
      held_data = rec_data;
      held_last = rec_last;
      tick;
    end
    checks++; if ({seen_done, 32'(got), 32'(rd_cnt - base_rd)} !== {1'b1, 32'd5, 32'd6}) begin errors++; $display("FAIL bp_total got done=%b recs=%0d reads=%0d exp 1/5/6", seen_done, got, rd_cnt - base_rd); end
    rec_ready = 1'b1;
    tick;
  endtask

  task automatic test_len_error;
    int got;
    logic seen_done;
    mem[B] = {32'h0000_0003, 32'h0000_001C};
    rec_ready = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    tick; tick;
    checks++; if ({len_error, record_count, header_valid} !== {1'b1, 29'd3, 1'b1}) begin errors++; $display("FAIL frac_header got %b/%0d/%b exp 1/3/1", len_error, record_count, header_valid); end
    got = 0; seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (done) seen_done = 1'b1;
      if (rec_valid) got++;
      tick;
    end
    checks++; if ({seen_done, 32'(got)} !== {1'b1, 32'd3}) begin errors++; $display("FAIL frac_total got %b/%0d exp 1/3", seen_done, got); end

    mem[B] = {32'h0000_0004, 32'h0000_0800};
    start = 1'b1; tick; start = 1'b0;
    tick; tick;
    checks++; if ({len_error, record_count} !== {1'b1, 29'd121}) begin errors++; $display("FAIL clamp_header got %b/%0d exp 1/121", len_error, record_count); end
    got = 0; seen_done = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      if (done) seen_done = 1'b1;
      if (rec_valid) begin
        checks++; if ({rec_last, rec_data} !== {(got == 120), mem[B+1+got][31:0]}) begin errors++; $display("FAIL clamp_data rec%0d got %b/%h exp %b/%h", got, rec_last, rec_data, (got == 120), mem[B+1+got][31:0]); end
        got++;
      end
      tick;
    end
    checks++; if ({seen_done, 32'(got), last_addr} !== {1'b1, 32'd121, 14'h3FFF}) begin errors++; $display("FAIL clamp_total got %b/%0d/%h exp 1/121/3fff", seen_done, got, last_addr); end
  endtask

  task automatic test_reset_mid;
    int base_rd, got, dones;
    mem[B] = {32'h0000_000A, 32'h0000_0020};
    rec_ready = 1'b1;
    got = 0;
    start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (rec_valid) got++;
      tick;
    end
    checks++; if (got !== 2) begin errors++; $display("FAIL mid_pre got %0d exp 2", got); end
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, done, header_valid, len_error, memory_read, rec_valid, rec_last} !== 7'd0) begin errors++; $display("FAIL mid_flags got %b exp 0", {busy, done, header_valid, len_error, memory_read, rec_valid, rec_last}); end
    checks++; if ({subject_id, record_count, memory_address, rec_data} !== 107'd0) begin errors++; $display("FAIL mid_buses got %h exp 0", {subject_id, record_count, memory_address, rec_data}); end
    tick;
    reset_n = 1'b1;
    tick;
    base_rd = rd_cnt;
    start = 1'b1; tick; start = 1'b0;
    checks++; if ({memory_read, memory_address, busy} !== {1'b1, 14'(B), 1'b1}) begin errors++; $display("FAIL restart_hdr got %b/%h/%b exp 1/%h/1", memory_read, memory_address, busy, 14'(B)); end
    tick;
    start = 1'b1; tick; start = 1'b0;
    got = 0; dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dones++;
      if (rec_valid) begin
        checks++; if ({rec_last, rec_data} !== {(got == 3), mem[B+1+got][31:0]}) begin errors++; $display("FAIL restart_data rec%0d got %b/%h exp %b/%h", got, rec_last, rec_data, (got == 3), mem[B+1+got][31:0]); end
        got++;
      end
      tick;
    end
    checks++; if ({32'(got), 32'(dones), 32'(rd_cnt - base_rd), busy} !== {32'd4, 32'd1, 32'd5, 1'b0}) begin errors++; $display("FAIL restart_total got recs=%0d dones=%0d reads=%0d busy=%b exp 4/1/5/0", got, dones, rd_cnt - base_rd, busy); end
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) begin
      mem[a] = {32'h1234_0000 | 32'(a), 32'hC300_0000 | 32'(a)};
    end
    test_reset;
    test_basic;
    test_zero_len;
    test_backpressure;
    test_len_error;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
